// File: rtl/fetch_unit.sv
// fetch_unit: 8080 instruction fetch stage. Reads opcode and operand bytes from
// byte-wide memory and presents {opcode, byte2, byte3} to decode over valid/ready.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_ren,
    output logic [15:0] mem_raddr,
    input  logic [7:0]  mem_rdata,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_addr,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [23:0] ins,
    output logic [15:0] ins_pc,
    output logic [1:0]  ins_len
);

    typedef enum logic [2:0] {ISSUE_OP, CAP_OP, CAP_B2, CAP_B3, VALID} state_t;

    state_t      state, state_next;
    logic [15:0] fpc;
    logic [1:0]  len;
    logic [7:0]  b1, b2, b3;
    logic [1:0]  op_len;

    // Instruction length from the opcode byte alone.
    function automatic logic [1:0] decode_len(input logic [7:0] op);
        logic [1:0] n;
        case (op)
            8'h22, 8'h2A, 8'h32, 8'h3A, 8'hC3, 8'hCB,
            8'hCD, 8'hDD, 8'hED, 8'hFD: n = 2'd3;
            8'hD3, 8'hDB:               n = 2'd2;
            default: begin
                if ((op & 8'hCF) == 8'h01 || (op & 8'hC7) == 8'hC2 ||
                    (op & 8'hC7) == 8'hC4)
                    n = 2'd3;
                else if ((op & 8'hC7) == 8'h06 || (op & 8'hC7) == 8'hC6)
                    n = 2'd2;
                else
                    n = 2'd1;
            end
        endcase
        return n;
    endfunction

    assign op_len  = decode_len(mem_rdata);
    assign ins     = {b1, b2, b3};
    assign ins_pc  = fpc;
    assign ins_len = len;

    always_comb begin
        state_next = state;
        mem_ren    = 1'b0;
        mem_raddr  = fpc;
        ins_valid  = 1'b0;
        case (state)
            ISSUE_OP: begin
                mem_ren    = 1'b1;
                state_next = CAP_OP;
            end
            CAP_OP: begin
                if (op_len != 2'd1) begin
                    mem_ren    = 1'b1;
                    mem_raddr  = fpc + 16'd1;
                    state_next = CAP_B2;
                end else begin
                    state_next = VALID;
                end
            end
            CAP_B2: begin
                if (len == 2'd3) begin
                    mem_ren    = 1'b1;
                    mem_raddr  = fpc + 16'd2;
                    state_next = CAP_B3;
                end else begin
                    state_next = VALID;
                end
            end
            CAP_B3: state_next = VALID;
            VALID: begin
                ins_valid = 1'b1;
                // Accepting overlaps the next opcode read, so ISSUE_OP is skipped.
                if (ins_ready) begin
                    mem_ren    = 1'b1;
                    mem_raddr  = fpc + {14'd0, len};
                    state_next = CAP_OP;
                end
            end
            default: state_next = ISSUE_OP;
        endcase
        if (redirect_valid)
            state_next = ISSUE_OP;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ISSUE_OP;
            fpc   <= RESET_PC;
            len   <= 2'd1;
            b1    <= 8'h00;
            b2    <= 8'h00;
            b3    <= 8'h00;
        end else begin
            state <= state_next;
            if (redirect_valid) begin
                fpc <= redirect_addr;
                b1  <= 8'h00;
                b2  <= 8'h00;
                b3  <= 8'h00;
            end else begin
                case (state)
                    CAP_OP: begin
                        b1  <= mem_rdata;
                        len <= op_len;
                    end
                    CAP_B2: b2 <= mem_rdata;
                    CAP_B3: b3 <= mem_rdata;
                    VALID: begin
                        if (ins_ready) begin
                            fpc <= fpc + {14'd0, len};
                            b1  <= 8'h00;
                            b2  <= 8'h00;
                            b3  <= 8'h00;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit with a byte memory model,
// a cycle-level vector table, directed corner cases and a randomized stream.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_ren;
    logic [15:0] mem_raddr;
    logic [7:0]  mem_rdata;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_addr = 16'h0000;
    logic        ins_valid;
    logic        ins_ready = 1'b0;
    logic [23:0] ins;
    logic [15:0] ins_pc;
    logic [1:0]  ins_len;

    logic [7:0] mem [0:65535];
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        ready;
        logic        exp_valid;
        logic [23:0] exp_ins;
        logic [15:0] exp_pc;
        logic [1:0]  exp_len;
        logic        exp_ren;
        logic [15:0] exp_raddr;
    } vec_t;

    vec_t vecs [10];

    fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_ren        (mem_ren),
        .mem_raddr      (mem_raddr),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .ins_valid      (ins_valid),
        .ins_ready      (ins_ready),
        .ins            (ins),
        .ins_pc         (ins_pc),
        .ins_len        (ins_len)
    );

    always #5 clk = ~clk;

    // One-cycle read latency memory.
    always @(posedge clk)
        if (mem_ren) mem_rdata <= mem[mem_raddr];

    // Reference length rules, written from the opcode classes.
    function automatic int ref_len(input logic [7:0] op);
        logic [1:0] hi;
        logic [2:0] lo;
        hi = op[7:6];
        lo = op[2:0];
        if (op inside {8'h22, 8'h2A, 8'h32, 8'h3A, 8'hC3, 8'hCB, 8'hCD, 8'hDD, 8'hED, 8'hFD})
            return 3;
        if (hi == 2'd0 && op[3:0] == 4'h1) return 3;
        if (hi == 2'd3 && (lo == 3'd2 || lo == 3'd4)) return 3;
        if ((hi == 2'd0 || hi == 2'd3) && lo == 3'd6) return 2;
        if (op == 8'hD3 || op == 8'hDB) return 2;
        return 1;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus_redirect(input logic [15:0] addr);
        redirect_valid = 1'b1;
        redirect_addr  = addr;
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    task automatic wait_valid(input int max_cycles, input string name);
        bit found;
        int i;
        found = 1'b0;
        i = 0;
        while (!found && i < max_cycles) begin
            #1;
            if (ins_valid) found = 1'b1;
            else @(negedge clk);
            i++;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL %s: no ins_valid within %0d cycles", name, max_cycles);
        end
    endtask

    task automatic check_ins(input string name, input logic [23:0] e_ins,
                             input logic [15:0] e_pc, input logic [1:0] e_len);
        check_output({name, " ins"}, ins, e_ins);
        check_output({name, " pc"}, ins_pc, e_pc);
        check_output({name, " len"}, ins_len, e_len);
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < 10; i++) begin
            ins_ready = vecs[i].ready;
            #1;
            check_output($sformatf("%s c%0d valid", tag, i), ins_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid)
                check_ins($sformatf("%s c%0d", tag, i), vecs[i].exp_ins,
                          vecs[i].exp_pc, vecs[i].exp_len);
            check_output($sformatf("%s c%0d ren", tag, i), mem_ren, vecs[i].exp_ren);
            if (vecs[i].exp_ren)
                check_output($sformatf("%s c%0d raddr", tag, i), mem_raddr, vecs[i].exp_raddr);
            @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] exp_pc;
        logic [15:0] raddr;
        logic [23:0] exp_ins;
        int          exp_len;
        int          transfers;
        int          cyc;
        bit          redir;

        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        mem[16'h0000] = 8'h00; mem[16'h0001] = 8'h3E; mem[16'h0002] = 8'h42;
        mem[16'h0003] = 8'hC3; mem[16'h0004] = 8'h34; mem[16'h0005] = 8'h12;
        mem[16'h0200] = 8'h06; mem[16'h0201] = 8'h55; mem[16'h0202] = 8'h00;
        mem[16'h0300] = 8'h01; mem[16'h0301] = 8'h11; mem[16'h0302] = 8'h22;
        mem[16'h0100] = 8'h3E; mem[16'h0101] = 8'h77;
        mem[16'hFFFF] = 8'hCD;
        mem[16'h0500] = 8'h00;
        mem[16'h0600] = 8'hC6; mem[16'h0601] = 8'h12;

        vecs[0] = '{1'b1, 1'b0, 24'h0,      16'h0000, 2'd0, 1'b1, 16'h0000};
        vecs[1] = '{1'b1, 1'b0, 24'h0,      16'h0000, 2'd0, 1'b0, 16'h0000};
        vecs[2] = '{1'b1, 1'b1, 24'h000000, 16'h0000, 2'd1, 1'b1, 16'h0001};
        vecs[3] = '{1'b1, 1'b0, 24'h0,      16'h0000, 2'd0, 1'b1, 16'h0002};
        vecs[4] = '{1'b1, 1'b0, 24'h0,      16'h0000, 2'd0, 1'b0, 16'h0000};
        vecs[5] = '{1'b1, 1'b1, 24'h3E4200, 16'h0001, 2'd2, 1'b1, 16'h0003};
        vecs[6] = '{1'b1, 1'b0, 24'h0,      16'h0000, 2'd0, 1'b1, 16'h0004};
        vecs[7] = '{1'b1, 1'b0, 24'h0,      16'h0000, 2'd0, 1'b1, 16'h0005};
        vecs[8] = '{1'b1, 1'b0, 24'h0,      16'h0000, 2'd0, 1'b0, 16'h0000};
        vecs[9] = '{1'b1, 1'b1, 24'hC33412, 16'h0003, 2'd3, 1'b1, 16'h0006};

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_output("reset valid", ins_valid, 1'b0);
        check_output("reset ins", ins, 24'h0);
        check_output("reset pc", ins_pc, 16'h0000);
        check_output("reset len", ins_len, 2'd1);
        check_output("reset ren", mem_ren, 1'b1);
        check_output("reset raddr", mem_raddr, 16'h0000);
        rst_n = 1'b1;
        run_table("boot");

        // Backpressure
        ins_ready = 1'b0;
        apply_stimulus_redirect(16'h0200);
        wait_valid(10, "bp wait");
        for (int k = 0; k < 5; k++) begin
            check_output($sformatf("bp hold%0d valid", k), ins_valid, 1'b1);
            check_ins($sformatf("bp hold%0d", k), 24'h065500, 16'h0200, 2'd2);
            check_output($sformatf("bp hold%0d ren", k), mem_ren, 1'b0);
            @(negedge clk);
            #1;
        end
        ins_ready = 1'b1;
        #1;
        check_output("bp accept ren", mem_ren, 1'b1);
        check_output("bp accept raddr", mem_raddr, 16'h0202);
        @(negedge clk);
        ins_ready = 1'b0;
        #1;
        check_output("bp after valid", ins_valid, 1'b0);
        wait_valid(10, "bp next wait");
        check_ins("bp next", 24'h000000, 16'h0202, 2'd1);

        // Redirect during CAP_B2 of an LXI
        ins_ready = 1'b1;
        apply_stimulus_redirect(16'h0300);
        @(negedge clk);
        @(negedge clk);
        #1;
        check_output("mid b2 ren", mem_ren, 1'b1);
        check_output("mid b2 raddr", mem_raddr, 16'h0302);
        apply_stimulus_redirect(16'h0100);
        for (int k = 1; k <= 3; k++) begin
            #1;
            check_output($sformatf("mid R+%0d valid", k), ins_valid, 1'b0);
            @(negedge clk);
        end
        #1;
        check_output("mid R+4 valid", ins_valid, 1'b1);
        check_ins("mid target", 24'h3E7700, 16'h0100, 2'd2);

        // Operand fetch wraps past FFFF
        mem[16'h0001] = 8'h80;
        apply_stimulus_redirect(16'hFFFF);
        wait_valid(10, "wrap wait");
        check_ins("wrap", 24'hCD0080, 16'hFFFF, 2'd3);
        @(negedge clk);
        wait_valid(10, "wrap next wait");
        check_ins("wrap next", 24'h420000, 16'h0002, 2'd1);
        mem[16'h0001] = 8'h3E;

        // Redirect and ready together in VALID
        ins_ready = 1'b0;
        apply_stimulus_redirect(16'h0500);
        wait_valid(10, "rr wait");
        check_ins("rr current", 24'h000000, 16'h0500, 2'd1);
        ins_ready = 1'b1;
        apply_stimulus_redirect(16'h0600);
        #1;
        check_output("rr after valid", ins_valid, 1'b0);
        check_output("rr after ren", mem_ren, 1'b1);
        check_output("rr after raddr", mem_raddr, 16'h0600);
        wait_valid(10, "rr next wait");
        check_ins("rr next", 24'hC61200, 16'h0600, 2'd2);

        // Reset during CAP_B3, then the boot sequence again
        apply_stimulus_redirect(16'h0300);
        repeat (3) @(negedge clk);
        #1;
        check_output("rst b3 ren", mem_ren, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check_output("rst mid valid", ins_valid, 1'b0);
        check_output("rst mid ren", mem_ren, 1'b1);
        check_output("rst mid raddr", mem_raddr, 16'h0000);
        rst_n = 1'b1;
        run_table("reboot");

        // Random stream against the reference model
        for (int round = 0; round < 6; round++) begin
            ins_ready = 1'b0;
            exp_pc = 16'($urandom);
            apply_stimulus_redirect(exp_pc);
            transfers = 0;
            cyc = 0;
            while (transfers < 15 && cyc < 300) begin
                ins_ready = ($urandom_range(0, 3) != 0);
                redir = ($urandom_range(0, 19) == 0);
                if (redir) begin
                    redirect_valid = 1'b1;
                    redirect_addr  = 16'($urandom);
                end
                #1;
                if (ins_valid) begin
                    exp_len = ref_len(mem[exp_pc]);
                    raddr = exp_pc + 16'd1;
                    exp_ins[23:16] = mem[exp_pc];
                    exp_ins[15:8]  = (exp_len >= 2) ? mem[raddr] : 8'h00;
                    raddr = exp_pc + 16'd2;
                    exp_ins[7:0]   = (exp_len == 3) ? mem[raddr] : 8'h00;
                    check_ins($sformatf("rnd%0d t%0d", round, transfers),
                              exp_ins, exp_pc, 2'(exp_len));
                    if (!ins_ready && !redir)
                        check_output($sformatf("rnd%0d stall ren", round), mem_ren, 1'b0);
                    if (ins_ready) begin
                        transfers++;
                        exp_pc = exp_pc + 16'(exp_len);
                    end
                end
                if (redir) exp_pc = redirect_addr;
                @(negedge clk);
                redirect_valid = 1'b0;
                cyc++;
            end
            check_output($sformatf("rnd%0d transfers", round), transfers, 15);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
